mc_control: RTL
===============

MC_CONTROL -- requirements
Module: mc_control (multi-cycle MIPS main control FSM; drives the datapath control inputs, consumes opcode/funct/zero)

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  instr[31:26] from datapath.
REQ-005 funct  in  6  instr[5:0] from datapath.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 memtoreg, regdst, iord, pcsrc, alusrca, irwrite, memwrite, regwrite  out  1 each  datapath selects/enables.
REQ-008 alusrcb  out  2  00=B, 01=const 4, 10=signimm, 11=signimm<<2.
REQ-009 pcen  out  1  PC register enable.
REQ-010 aluop  out  2  00=add, 01=sub, 10=use funct.
REQ-011 alucontrol  out  3  ALU operation.
REQ-012 state  out  4  current state encoding, debug.
REQ-013 illegal  out  1  one-cycle pulse on unsupported opcode.

Function
REQ-014 Moore FSM, states/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10; codes 11-15 SHALL go to FETCH next cycle with all enables 0.
REQ-015 Transitions: FETCH->DECODE; DECODE->MEMADR (lw 100011, sw 101011), EXECUTE (000000), BRANCH (000100), ADDIEX (001000), else FETCH; MEMADR->MEMRD (lw) / MEMWR (sw); MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB->FETCH.
REQ-016 Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, illegal 2.
REQ-017 Outputs are combinational from state; every signal not listed for a state is 0.
REQ-018 FETCH: irwrite=1, alusrcb=01, pcwrite=1.
REQ-019 DECODE: alusrcb=11. MEMADR: alusrca=1, alusrcb=10. MEMRD: iord=1. MEMWB: memtoreg=1, regwrite=1. MEMWR: iord=1, memwrite=1.
REQ-020 EXECUTE: alusrca=1, aluop=10. ALUWB: regdst=1, regwrite=1. ADDIEX: alusrca=1, alusrcb=10. ADDIWB: regwrite=1.
REQ-021 BRANCH: alusrca=1, aluop=01, pcsrc=1, branch=1.
REQ-022 pcen = pcwrite | (branch & zero), combinational in zero.
REQ-023 alucontrol: aluop 00->010, 01->110, 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010.
REQ-024 illegal=1 only in the DECODE cycle with an unsupported opcode.
REQ-025 Unknown funct on R-type SHALL still complete EXECUTE/ALUWB normally.

Reset
REQ-026 reset low SHALL force state=FETCH immediately, independent of clk.
REQ-027 While reset low, irwrite, pcen, regwrite, memwrite, illegal SHALL be 0; other outputs SHALL equal FETCH decode.
REQ-028 Reset asserted mid-instruction SHALL abandon it; first rising edge after release SHALL perform FETCH writes.

Configuration
REQ-029 Macro MC_CONTROL_ADDI_EN: defined -> addi supported per REQ-015/020; undefined -> ADDIEX/ADDIWB absent, opcode 001000 treated as illegal (DECODE->FETCH, illegal pulse).

Verification
REQ-030 lw (opcode 100011): states 0,1,2,3,4,0; memtoreg=regwrite=1 only in state 4; iord=1 in state 3.
REQ-031 sw (101011): states 0,1,2,5,0; memwrite=1 for exactly one cycle.
REQ-032 R-type funct 101010: alucontrol=111 in EXECUTE; regdst=regwrite=1 in ALUWB.
REQ-033 beq with zero=1 -> pcen=1, pcsrc=1 in BRANCH; zero=0 -> pcen=0.
REQ-034 opcode 111111 -> illegal=1 in DECODE, FETCH next, no write enables.
REQ-035 reset low during MEMRD -> state=0 immediately, enables 0; after release, FETCH with irwrite=pcen=1.

Source files
------------

// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control -- main control FSM for a multi-cycle MIPS datapath.
//
// A Moore state machine sequences each instruction through fetch, decode and
// the execute/memory/writeback steps it needs. It then drives the datapath
// select and enable lines from the current state.
//
// Optional feature (macro MC_CONTROL_ADDI_EN):
//   defined   -> addi (opcode 001000) runs through ADDIEX/ADDIWB.
//   undefined -> those states do not exist and addi is treated as an
//                unsupported opcode.
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   asynchronous, active-low
//   opcode      in   instr[31:26]
//   funct       in   instr[5:0]
//   zero        in   ALU zero flag
//   memtoreg, regdst, iord, pcsrc, alusrca,
//   irwrite, memwrite, regwrite  out  datapath selects/enables
//   alusrcb     out  00=B, 01=4, 10=signimm, 11=signimm<<2
//   pcen        out  PC enable = pcwrite | (branch & zero)
//   aluop       out  00=add, 01=sub, 10=decode funct
//   alucontrol  out  ALU operation
//   state       out  current state code (debug)
//   illegal     out  pulse in DECODE for an unsupported opcode
// -----------------------------------------------------------------------------
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       pcsrc,
  output logic       alusrca,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] alusrcb,
  output logic       pcen,
  output logic [1:0] aluop,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
`ifdef MC_CONTROL_ADDI_EN
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10
`else
    BRANCH  = 4'd8
`endif
  } state_e;

  state_e state_q, state_d;

  // Raw per-state decode, before the reset gating of the write enables.
  logic irwrite_s, memwrite_s, regwrite_s, pcwrite_s, branch_s, illegal_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next state. Codes with no state assigned fall into the default arm and
  // return to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
`ifdef MC_CONTROL_ADDI_EN
      ADDIEX:  state_d = ADDIWB;
`endif
      default: state_d = FETCH;
    endcase
  end

  // Moore output decode. Every signal not named in a state stays 0.
  always_comb begin
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    iord       = 1'b0;
    pcsrc      = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    illegal_s  = 1'b0;
    case (state_q)
      FETCH: begin
        irwrite_s = 1'b1;
        alusrcb   = 2'b01;
        pcwrite_s = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ: illegal_s = 1'b0;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:                        illegal_s = 1'b0;
`endif
          default:                        illegal_s = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 1'b1;
        branch_s = 1'b1;
      end
`ifdef MC_CONTROL_ADDI_EN
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite_s = 1'b1;
`endif
      default: ;
    endcase
  end

  // ALU decoder. An unknown funct falls back to add, so the R-type sequence
  // still completes normally.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
    endcase
  end

  // While reset is held, the state already decodes as FETCH. Only the
  // architectural write enables are masked, so no fetch side effects occur
  // until the first edge after release.
  assign irwrite  = reset & irwrite_s;
  assign memwrite = reset & memwrite_s;
  assign regwrite = reset & regwrite_s;
  assign illegal  = reset & illegal_s;
  assign pcen     = reset & (pcwrite_s | (branch_s & zero));
  assign state    = state_q;

endmodule
